div_sched: RTL
==============

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter: WIDTH, default 64, operand/result width of the shared divider.
REQ-002 Parameter: TIMEOUT, default 80, maximum WAIT cycles before a divide is aborted.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req  in  2  per-port request; port i holds req[i] high until granted.
REQ-006 n0, d0  in  WIDTH each  port 0 dividend and divisor; sampled on the grant edge.
REQ-007 n1, d1  in  WIDTH each  port 1 dividend and divisor; sampled on the grant edge.
REQ-008 gnt  out  2  one-hot, one-cycle accept pulse; combinational from state IDLE and req.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 res_valid  out  1  one-cycle result strobe.
REQ-011 res_id  out  1  port that owns the result; valid with res_valid.
REQ-012 res_q, res_r  out  WIDTH each  quotient and remainder; valid with res_valid.
REQ-013 res_err  out  2  00 ok, 01 divide-by-zero, 10 timeout; valid with res_valid.
REQ-014 div_en  out  1  one-cycle start pulse to the divider.
REQ-015 div_init  out  WIDTH  divider iteration count; constant WIDTH.
REQ-016 div_n, div_d  out  WIDTH each  latched operands; stable from ISSUE until leaving WAIT.
REQ-017 div_q, div_r  in  WIDTH each  divider quotient and remainder.
REQ-018 div_ready  in  1  divider completion flag.

Function
REQ-019 States: IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE with any req bit high: grant one port, latch its operands and id, and pulse gnt[id] that cycle.
REQ-021 Arbitration: round-robin; priority pointer resets to port 0 and moves to the other port after every grant.
REQ-022 Single request: it wins regardless of the pointer.
REQ-023 Grant with nonzero divisor: next state ISSUE.
REQ-024 Grant with divisor == 0: next state RESP with res_q = all ones, res_r = dividend, res_err = 01; no div_en is issued.
REQ-025 ISSUE lasts one cycle: div_en = 1, then next state WAIT with the wait counter cleared.
REQ-026 WAIT: div_ready is ignored in the first WAIT cycle, since a stale ready may remain from the previous operation.
REQ-027 WAIT, second cycle onward: the first sampled div_ready = 1 captures div_q/div_r and moves to RESP with res_err = 00.
REQ-028 WAIT: the counter increments every cycle; when it reaches TIMEOUT without acceptance, move to RESP with res_q = res_r = 0 and res_err = 10.
REQ-029 RESP lasts one cycle: res_valid = 1 with the registered res_id/q/r/err, then IDLE.
REQ-030 Requests are not accepted in RESP; earliest next grant is the cycle after RESP.
REQ-031 req is ignored while busy, and gnt stays 00.
REQ-032 A req dropped before grant has no effect.
REQ-033 res_* hold their last values outside RESP; only res_valid qualifies them.
REQ-034 Latency from grant cycle T for a divide whose ready is first accepted at cycle T+2+k (k >= 1): res_valid at T+3+k.
REQ-035 div_ready while not in WAIT: ignored.

Reset
REQ-036 rst high at a clock edge: state IDLE, pointer 0, wait counter 0.
REQ-037 rst high at a clock edge: gnt, busy, res_valid and div_en = 0.
REQ-038 rst high at a clock edge: res_id, res_q, res_r, res_err, div_n and div_d = 0.
REQ-039 rst high at a clock edge: div_init = WIDTH.
REQ-040 Reset mid-operation (ISSUE, WAIT or RESP) discards the operation; no res_valid is produced for it.

Verification
REQ-041 req=01, n0=100, d0=7, model ready 66 cycles after div_en -> gnt=01 one cycle, div_en one cycle with div_init=64, res_valid with q=14, r=2, id=0, err=00.
REQ-042 req=11 held after reset -> grants in order port 0, port 1, port 0, port 1, one res_valid per grant with matching res_id.
REQ-043 req=10, n1=5, d1=0 -> gnt=10 at T, res_valid at T+1 with q=all ones, r=5, err=01, div_en never high.
REQ-044 Model never asserts ready -> res_valid with err=10 and q=r=0 exactly TIMEOUT cycles after the first WAIT cycle.
REQ-045 div_ready held high through ISSUE and the first WAIT cycle, then low 10 cycles, then high -> capture only on the later high.
REQ-046 rst pulsed during WAIT -> busy=0 next cycle; a later div_ready produces no res_valid; the next req=11 grants port 0.

Source files
------------

// File: rtl/div_sched.sv
// Two-port round-robin front end for a shared iterative divider.
// Handles divide-by-zero locally and aborts divides whose ready never arrives.
module div_sched #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned TIMEOUT = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] n0,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] d1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res_q,
  output logic [WIDTH-1:0] res_r,
  output logic [1:0]       res_err,
  output logic             div_en,
  output logic [WIDTH-1:0] div_init,
  output logic [WIDTH-1:0] div_n,
  output logic [WIDTH-1:0] div_d,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  input  logic             div_ready
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] n_q, n_d, d_q, d_d;
  logic [WIDTH-1:0] rq_q, rq_d, rr_q, rr_d;
  logic [1:0]       err_q, err_d;
  logic             sel;
  logic [WIDTH-1:0] sel_n, sel_d;

  // Pointer only matters when both ports contend.
  always_comb begin
    if (req == 2'b11) sel = ptr_q;
    else              sel = req[1];
    sel_n = sel ? n1 : n0;
    sel_d = sel ? d1 : d0;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    n_d     = n_q;
    d_d     = d_q;
    rq_d    = rq_q;
    rr_d    = rr_q;
    err_d   = err_q;
    gnt     = 2'b00;
    div_en  = 1'b0;
    case (state_q)
      StIdle: begin
        if ((|req) && !rst) begin
          gnt   = sel ? 2'b10 : 2'b01;
          id_d  = sel;
          n_d   = sel_n;
          d_d   = sel_d;
          ptr_d = ~sel;
          if (sel_d == '0) begin
            rq_d    = '1;
            rr_d    = sel_n;
            err_d   = 2'b01;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        div_en  = 1'b1;
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // Ready in the first WAIT cycle may be left over from the previous divide.
        if ((cnt_q != '0) && div_ready) begin
          rq_d    = div_q;
          rr_d    = div_r;
          err_d   = 2'b00;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          rq_d    = '0;
          rr_d    = '0;
          err_d   = 2'b10;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      n_q     <= '0;
      d_q     <= '0;
      rq_q    <= '0;
      rr_q    <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      n_q     <= n_d;
      d_q     <= d_d;
      rq_q    <= rq_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StResp);
  assign res_id    = id_q;
  assign res_q     = rq_q;
  assign res_r     = rr_q;
  assign res_err   = err_q;
  assign div_init  = WIDTH'(WIDTH);
  assign div_n     = n_q;
  assign div_d     = d_q;

endmodule
